controller_sequencer: RTL
=========================

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port RUN, input, 1 bit: 1 = advance T-state each clock; 0 = hold.
REQ-005 SHALL have port OPCODE, input, 4 bits: instruction register upper nibble; valid during T4-T6.
REQ-006 SHALL have port Cp, output, 1 bit: program counter increment (active-high).
REQ-007 SHALL have port Ep, output, 1 bit: program counter drives W bus (active-high).
REQ-008 SHALL have ports nLm, nCE, nLi, nEi, nLa, nLb, nLo, outputs, 1 bit each: MAR load, RAM enable, IR load, IR enable, A load, B load, output-register load (all active-low).
REQ-009 SHALL have ports Ea, Su, Eu, outputs, 1 bit each: accumulator enable, subtract, adder enable (all active-high).
REQ-010 SHALL have port HLT, output, 1 bit: 1 while halted.
REQ-011 SHALL have port T_STATE, output, 6 bits: one-hot current T-state (bit0 = T1 ... bit5 = T6); all-zero when halted.

Function
REQ-012 SHALL sequence T1->T2->T3->T4->T5->T6->T1 on each rising CLK edge while RUN=1 and not halted.
REQ-013 SHALL hold the current T-state, and drive the inactive control word, while RUN=0; the sequence resumes at the held state when RUN returns to 1.
REQ-014 SHALL decode the control outputs combinationally from the current T-state and OPCODE, so that they are valid within the same cycle.
REQ-015 SHALL define the inactive control word as Cp=Ep=Ea=Su=Eu=0 and nLm=nCE=nLi=nEi=nLa=nLb=nLo=1; every signal not asserted below takes its inactive value.
REQ-016 SHALL decode the fetch states for all opcodes: T1 asserts Ep and nLm=0; T2 asserts Cp; T3 asserts nCE=0 and nLi=0.
REQ-017 SHALL decode LDA (0000): T4 nEi=0, nLm=0; T5 nCE=0, nLa=0; T6 no operation.
REQ-018 SHALL decode ADD (0001): T4 nEi=0, nLm=0; T5 nCE=0, nLb=0; T6 Eu=1, nLa=0.
REQ-019 SHALL decode SUB (0010) as ADD, except that T6 additionally asserts Su=1.
REQ-020 SHALL decode OUT (1110): T4 Ea=1, nLo=0; T5 and T6 no operation.
REQ-021 SHALL decode HLT (1111): at the T4 clock edge, enter HALTED; HLT=1, T_STATE=0 and the inactive control word persist until CLR.
REQ-022 SHALL treat undefined opcodes as no operation in T4-T6, then return to T1.
REQ-023 SHALL enter HALTED only from T4 with OPCODE=1111; RUN=0 in T4 defers the halt until RUN=1.
REQ-024 SHALL never assert Cp and Ep in the same cycle, nor more than one bus driver (Ep, nCE=0, nEi=0, Ea, Eu) per cycle.

Reset
REQ-025 SHALL, on CLR=1 at a rising edge, enter T1 regardless of state, RUN or OPCODE, including mid-instruction and from HALTED.
REQ-026 SHALL give CLR priority over RUN and over the halt transition.
REQ-027 SHALL produce these values in the cycle after reset: T_STATE=000001, HLT=0, Ep=1, nLm=0, all other outputs inactive.

Structure
REQ-028 SHALL take the opcode constants (LDA, ADD, SUB, OUT, HLT), the T-state indices, the control-word bit positions and the inactive control-word constant from shared package sap1_pkg.
REQ-029 SHALL build the T-state sequencer as sub-module ring_counter: 6-bit one-hot, with synchronous CLR, enable and halt inputs.
REQ-030 SHALL keep the opcode/T-state decode in controller_sequencer itself.

Verification
REQ-031 SHALL cover reset: CLR=1 for 2 cycles, then RUN=1 -> T_STATE 000001,000010,...,100000,000001; Ep=1 only in T1, Cp=1 only in T2.
REQ-032 SHALL cover ADD: OPCODE=0001 -> T4 nEi=0,nLm=0; T5 nCE=0,nLb=0; T6 Eu=1,nLa=0,Su=0. SUB (0010) -> identical, with Su=1 in T6.
REQ-033 SHALL cover LDA then OUT: OPCODE=0000 -> T5 nCE=0,nLa=0; next instruction OPCODE=1110 -> T4 Ea=1,nLo=0; T5 and T6 inactive.
REQ-034 SHALL cover HLT: OPCODE=1111 at T4 -> from the next cycle HLT=1, T_STATE=000000, inactive word for 20 cycles; CLR=1 -> T_STATE=000001, HLT=0.
REQ-035 SHALL cover RUN hold: RUN=0 during T3 for 5 cycles -> T_STATE stays 000100 with the inactive word; RUN=1 -> T4 follows.
REQ-036 SHALL cover reset mid-operation and undefined opcodes: CLR=1 during T5 of ADD -> next cycle T1; OPCODE=0101 -> T4-T6 inactive, then T1.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, T-state indices and control-word layout.
package sap1_pkg;

    // Instruction opcodes (upper nibble of the instruction register)
    localparam logic [3:0] op_lda = 4'b0000;
    localparam logic [3:0] op_add = 4'b0001;
    localparam logic [3:0] op_sub = 4'b0010;
    localparam logic [3:0] op_out = 4'b1110;
    localparam logic [3:0] op_hlt = 4'b1111;

    // Bit index of each T-state in the one-hot T_STATE vector
    localparam int unsigned t1_idx = 0;
    localparam int unsigned t2_idx = 1;
    localparam int unsigned t3_idx = 2;
    localparam int unsigned t4_idx = 3;
    localparam int unsigned t5_idx = 4;
    localparam int unsigned t6_idx = 5;

    // Control-word layout: {Cp, Ep, nLm, nCE, nLi, nEi, nLa, nLb, nLo, Ea, Su, Eu}
    localparam int unsigned cw_width = 12;
    localparam int unsigned cw_cp    = 11;
    localparam int unsigned cw_ep    = 10;
    localparam int unsigned cw_nlm   = 9;
    localparam int unsigned cw_nce   = 8;
    localparam int unsigned cw_nli   = 7;
    localparam int unsigned cw_nei   = 6;
    localparam int unsigned cw_nla   = 5;
    localparam int unsigned cw_nlb   = 4;
    localparam int unsigned cw_nlo   = 3;
    localparam int unsigned cw_ea    = 2;
    localparam int unsigned cw_su    = 1;
    localparam int unsigned cw_eu    = 0;

    // All active-high strobes low, all active-low strobes high
    localparam logic [cw_width-1:0] cw_inactive = 12'b0011_1111_1000;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot T-state ring with synchronous clear, enable and halt.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       halt_i,
    output logic [5:0] t_state_o,
    output logic       halted_o
);

    typedef enum logic [0:0] {StRun, StHalted} run_state_e;

    logic [5:0] ring_q;
    run_state_e state_q;

    // Clear wins over everything; a halt request freezes the ring at all-zero until the next clear
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            ring_q  <= 6'b000001;
            state_q <= StRun;
        end else if (en_i && state_q == StRun) begin
            if (halt_i) begin
                ring_q  <= 6'b000000;
                state_q <= StHalted;
            end else begin
                ring_q <= {ring_q[4:0], ring_q[5]};
            end
        end
    end

    assign t_state_o = ring_q;
    assign halted_o  = (state_q == StHalted);

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring plus combinational opcode/T-state control decode.
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       RUN,
    input  logic [3:0] OPCODE,
    output logic       Cp,
    output logic       Ep,
    output logic       nLm,
    output logic       nCE,
    output logic       nLi,
    output logic       nEi,
    output logic       nLa,
    output logic       nLb,
    output logic       nLo,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       HLT,
    output logic [5:0] T_STATE
);

    logic [5:0]          t_state;
    logic                halted;
    logic                halt_req;
    logic [cw_width-1:0] cw;

    // Halt is only taken from T4; the ring ignores it unless RUN advances the sequence
    assign halt_req = t_state[t4_idx] && (OPCODE == op_hlt);

    ring_counter u_ring (
        .clk_i    (CLK),
        .clr_i    (CLR),
        .en_i     (RUN),
        .halt_i   (halt_req),
        .t_state_o(t_state),
        .halted_o (halted)
    );

    // Decode the control word from the current T-state and opcode; idle word while held or halted
    always_comb begin
        cw = cw_inactive;
        if (RUN && !halted) begin
            unique case (1'b1)
                t_state[t1_idx]: begin
                    cw[cw_ep]  = 1'b1;
                    cw[cw_nlm] = 1'b0;
                end
                t_state[t2_idx]: begin
                    cw[cw_cp] = 1'b1;
                end
                t_state[t3_idx]: begin
                    cw[cw_nce] = 1'b0;
                    cw[cw_nli] = 1'b0;
                end
                t_state[t4_idx]: begin
                    case (OPCODE)
                        op_lda, op_add, op_sub: begin
                            cw[cw_nei] = 1'b0;
                            cw[cw_nlm] = 1'b0;
                        end
                        op_out: begin
                            cw[cw_ea]  = 1'b1;
                            cw[cw_nlo] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                t_state[t5_idx]: begin
                    case (OPCODE)
                        op_lda: begin
                            cw[cw_nce] = 1'b0;
                            cw[cw_nla] = 1'b0;
                        end
                        op_add, op_sub: begin
                            cw[cw_nce] = 1'b0;
                            cw[cw_nlb] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                t_state[t6_idx]: begin
                    case (OPCODE)
                        op_add: begin
                            cw[cw_eu]  = 1'b1;
                            cw[cw_nla] = 1'b0;
                        end
                        op_sub: begin
                            cw[cw_eu]  = 1'b1;
                            cw[cw_su]  = 1'b1;
                            cw[cw_nla] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign Cp      = cw[cw_cp];
    assign Ep      = cw[cw_ep];
    assign nLm     = cw[cw_nlm];
    assign nCE     = cw[cw_nce];
    assign nLi     = cw[cw_nli];
    assign nEi     = cw[cw_nei];
    assign nLa     = cw[cw_nla];
    assign nLb     = cw[cw_nlb];
    assign nLo     = cw[cw_nlo];
    assign Ea      = cw[cw_ea];
    assign Su      = cw[cw_su];
    assign Eu      = cw[cw_eu];
    assign HLT     = halted;
    assign T_STATE = t_state;

endmodule
